// File: rtl/cpu_pkg.sv
// Shared CPU package: memory-port arbiter state and owner encodings plus the
// default memory address/data widths used by the memory-side blocks.
package cpu_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-port arbiter bus: fetch requester, load/store requester and the
// memory macro side, all in one bundle.
//   slave  : the arbiter (takes requests/read data, drives grants/memory)
//   master : requesters plus memory model (drive requests/read data)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = cpu_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = cpu_pkg::DEF_DATA_W
);
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt;
  logic              o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;

  logic              i_ls_req;
  logic              i_ls_we;
  logic [ADDR_W-1:0] i_ls_addr;
  logic [DATA_W-1:0] i_ls_wdata;
  logic              o_ls_gnt;
  logic              o_ls_done;
  logic [DATA_W-1:0] o_ls_rdata;

  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  logic              o_busy;

  modport slave (
    input  i_if_req, i_if_addr, i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_mem_rdata,
    output o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_done, o_ls_rdata,
           o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
  );

  modport master (
    output i_if_req, i_if_addr, i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_mem_rdata,
    input  o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_done, o_ls_rdata,
           o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
  );
endinterface

// File: rtl/mem_port_arb_sel.sv
// Winner select for the shared memory port.
// Default: load/store has fixed priority; a fetch that has lost STARVE_MAX
// arbitrations in a row is forced to win.
// MEM_PORT_ARB_RR_EN defined: round-robin on conflicts, LS first after reset.
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   if_req_i, ls_req_i requests from fetch and load/store
//   idle_i             arbiter may grant this cycle
//   win_o              selected owner (meaningful when a grant is issued)
//   if_gnt_o, ls_gnt_o combinational grant strobes
module mem_port_arb_sel
  import cpu_pkg::*;
#(
`ifdef MEM_PORT_ARB_RR_EN
  parameter int unsigned UNUSED_W = 1
`else
  parameter int unsigned STARVE_MAX = 4
`endif
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       if_req_i,
  input  logic       ls_req_i,
  input  logic       idle_i,
  output arb_owner_e win_o,
  output logic       if_gnt_o,
  output logic       ls_gnt_o
);

`ifdef MEM_PORT_ARB_RR_EN
  // Set when LS should win the next conflict.
  logic pref_ls_q;

  always_comb begin
    win_o = OWN_IF;
    if (if_req_i && ls_req_i) win_o = pref_ls_q ? OWN_LS : OWN_IF;
    else if (ls_req_i)        win_o = OWN_LS;
  end

  // Only conflicts move the pointer; the loser of a conflict wins the next one.
  always_ff @(posedge i_clk) begin
    if (i_reset)                               pref_ls_q <= 1'b1;
    else if (idle_i && if_req_i && ls_req_i)   pref_ls_q <= (win_o == OWN_IF);
  end
`else
  localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);

  logic [SC_W-1:0] starve_q;
  logic            force_if;

  assign force_if = (starve_q == SC_W'(STARVE_MAX));

  always_comb begin
    win_o = OWN_LS;
    if (if_req_i && (!ls_req_i || force_if)) win_o = OWN_IF;
  end

  // Counts consecutive lost fetch arbitrations; saturates at STARVE_MAX.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      starve_q <= '0;
    end else if (idle_i) begin
      if (if_req_i && !if_gnt_o) begin
        if (!force_if) starve_q <= starve_q + SC_W'(1);
      end else begin
        starve_q <= '0;
      end
    end
  end
`endif

  always_comb begin
    if_gnt_o = 1'b0;
    ls_gnt_o = 1'b0;
    if (idle_i) begin
      if_gnt_o = if_req_i && (win_o == OWN_IF);
      ls_gnt_o = ls_req_i && (win_o == OWN_LS);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data/instruction memory between instruction fetch
// and load/store. Arbitrates per access in IDLE, holds the latched request on
// the memory for WAIT_CYC cycles, then pulses completion for one cycle.
// Build option: MEM_PORT_ARB_RR_EN selects round-robin arbitration instead of
// fixed LS priority with fetch starvation override.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   bus (slave)     requester handshakes, read data returns, memory port, busy
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned WAIT_CYC = 2
`ifdef MEM_PORT_ARB_RR_EN
`else
  ,
  parameter int unsigned STARVE_MAX = 4
`endif
) (
  input logic               i_clk,
  input logic               i_reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYC + 1);

  arb_state_e        state_q;
  arb_owner_e        owner_q;
  arb_owner_e        win;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;
  logic              we_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              if_rvalid_q;
  logic              ls_done_q;
  logic              idle;
  logic              if_gnt;
  logic              ls_gnt;

  // No grants while reset is asserted, even from IDLE.
  assign idle = (state_q == ST_IDLE) && !i_reset;

  mem_port_arb_sel
`ifdef MEM_PORT_ARB_RR_EN
`else
    #(.STARVE_MAX(STARVE_MAX))
`endif
  u_sel (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .if_req_i (bus.i_if_req),
    .ls_req_i (bus.i_ls_req),
    .idle_i   (idle),
    .win_o    (win),
    .if_gnt_o (if_gnt),
    .ls_gnt_o (ls_gnt)
  );

  // Access sequencer: latch on grant, hold the memory port, capture and respond.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      ls_done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (if_gnt || ls_gnt) begin
            owner_q  <= win;
            addr_q   <= ls_gnt ? bus.i_ls_addr : bus.i_if_addr;
            wdata_q  <= bus.i_ls_wdata;
            we_q     <= ls_gnt && bus.i_ls_we;
            mem_en_q <= 1'b1;
            mem_we_q <= ls_gnt && bus.i_ls_we;
            cnt_q    <= CNT_W'(WAIT_CYC - 1);
            state_q  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == '0) begin
            if (owner_q == OWN_IF)  if_rdata_q <= bus.i_mem_rdata;
            else if (!we_q)         ls_rdata_q <= bus.i_mem_rdata;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            if_rvalid_q <= (owner_q == OWN_IF);
            ls_done_q   <= (owner_q == OWN_LS);
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_if_gnt    = if_gnt;
  assign bus.o_ls_gnt    = ls_gnt;
  assign bus.o_if_rvalid = if_rvalid_q;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_ls_done   = ls_done_q;
  assign bus.o_ls_rdata  = ls_rdata_q;
  assign bus.o_mem_en    = mem_en_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timing reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_mem_port_arbiter;

  localparam int W = 2;
`ifndef MEM_PORT_ARB_RR_EN
  localparam int STARVE_MAX = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.WAIT_CYC(W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: one access occupies cycles g..g+W+1, next arbitration at g+W+2.
  int          free_at;
  int          g_at;
  bit          g_valid;
  bit          own_ls;
  bit          l_we;
  logic [15:0] l_addr;
  logic [15:0] l_wdata;
  logic [15:0] m_if_rdata;
  logic [15:0] m_ls_rdata;
  bit          rr_pref_ls;
  int          starve;
  bit          m_w_if;
  bit          m_w_ls;

  task automatic chk1(string nm, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk16(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    free_at    = cyc + 1;
    g_valid    = 1'b0;
    g_at       = 0;
    own_ls     = 1'b0;
    m_if_rdata = '0;
    m_ls_rdata = '0;
    rr_pref_ls = 1'b1;
    starve     = 0;
  endtask

  task automatic model_cycle();
    bit idle, e_en, e_we, e_rv, e_done, e_busy, both;
    idle   = (cyc >= free_at) && !rst;
    both   = bus.i_if_req && bus.i_ls_req;
    m_w_if = 1'b0;
    m_w_ls = 1'b0;
    if (idle && (bus.i_if_req || bus.i_ls_req)) begin
`ifdef MEM_PORT_ARB_RR_EN
      m_w_ls = both ? rr_pref_ls : bus.i_ls_req;
`else
      m_w_ls = bus.i_ls_req && !(bus.i_if_req && starve == STARVE_MAX);
`endif
      m_w_if = !m_w_ls;
    end
    e_en   = g_valid && (cyc >= g_at + 1) && (cyc <= g_at + W);
    e_we   = e_en && own_ls && l_we;
    e_rv   = g_valid && (cyc == g_at + W + 1) && !own_ls;
    e_done = g_valid && (cyc == g_at + W + 1) && own_ls;
    e_busy = g_valid && (cyc > g_at) && (cyc <= g_at + W + 1);

    chk1("if_gnt", bus.o_if_gnt, m_w_if);
    chk1("ls_gnt", bus.o_ls_gnt, m_w_ls);
    chk1("mem_en", bus.o_mem_en, e_en);
    chk1("mem_we", bus.o_mem_we, e_we);
    chk1("if_rvalid", bus.o_if_rvalid, e_rv);
    chk1("ls_done", bus.o_ls_done, e_done);
    chk1("busy", bus.o_busy, e_busy);
    chk16("if_rdata", bus.o_if_rdata, m_if_rdata);
    chk16("ls_rdata", bus.o_ls_rdata, m_ls_rdata);
    if (e_en) chk16("mem_addr", bus.o_mem_addr, l_addr);
    if (e_we) chk16("mem_wdata", bus.o_mem_wdata, l_wdata);

    if (rst) begin
      model_reset();
    end else begin
      if (g_valid && cyc == g_at + W) begin
        if (!own_ls)    m_if_rdata = bus.i_mem_rdata;
        else if (!l_we) m_ls_rdata = bus.i_mem_rdata;
      end
      if (idle) begin
`ifdef MEM_PORT_ARB_RR_EN
        if (both) rr_pref_ls = !m_w_ls;
`else
        if (bus.i_if_req && !m_w_if) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
        else                         starve = 0;
`endif
      end
      if (m_w_if || m_w_ls) begin
        g_valid = 1'b1;
        g_at    = cyc;
        free_at = cyc + W + 2;
        own_ls  = m_w_ls;
        l_addr  = m_w_ls ? bus.i_ls_addr : bus.i_if_addr;
        l_we    = m_w_ls && bus.i_ls_we;
        l_wdata = bus.i_ls_wdata;
      end
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ev();
    #1;
    model_cycle();
  endtask

  task automatic clear_in();
    bus.i_if_req   = 1'b0;
    bus.i_if_addr  = '0;
    bus.i_ls_req   = 1'b0;
    bus.i_ls_we    = 1'b0;
    bus.i_ls_addr  = '0;
    bus.i_ls_wdata = '0;
    bus.i_mem_rdata = '0;
  endtask

  task automatic do_reset();
    nxt(); rst = 1'b1; clear_in(); ev();
    nxt(); rst = 1'b1; ev();
    nxt(); rst = 1'b0; ev();
  endtask

  // Fetch or load from addr; memory returns rd on the last access cycle.
  task automatic read_txn(bit ls, logic [15:0] addr, logic [15:0] rd, string nm);
    nxt();
    if (ls) begin bus.i_ls_req = 1'b1; bus.i_ls_we = 1'b0; bus.i_ls_addr = addr; end
    else    begin bus.i_if_req = 1'b1; bus.i_if_addr = addr; end
    ev();
    chk1({nm, "_gnt0"}, ls ? bus.o_ls_gnt : bus.o_if_gnt, 1'b1);
    nxt(); bus.i_if_req = 1'b0; bus.i_ls_req = 1'b0; ev();
    chk1({nm, "_en1"}, bus.o_mem_en, 1'b1);
    chk16({nm, "_addr1"}, bus.o_mem_addr, addr);
    chk1({nm, "_we1"}, bus.o_mem_we, 1'b0);
    nxt(); bus.i_mem_rdata = rd; ev();
    chk1({nm, "_en2"}, bus.o_mem_en, 1'b1);
    nxt(); bus.i_mem_rdata = 16'h0000; ev();
    chk1({nm, "_cmpl3"}, ls ? bus.o_ls_done : bus.o_if_rvalid, 1'b1);
    chk1({nm, "_other3"}, ls ? bus.o_if_rvalid : bus.o_ls_done, 1'b0);
    chk16({nm, "_rdata3"}, ls ? bus.o_ls_rdata : bus.o_if_rdata, rd);
    nxt(); ev();
  endtask

  bit pend_if;
  bit pend_ls;
  bit exp_ls[6];

  initial begin
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    do_reset();
    chk1("rst_busy", bus.o_busy, 1'b0);
    chk1("rst_mem_en", bus.o_mem_en, 1'b0);
    chk16("rst_mem_addr", bus.o_mem_addr, 16'h0000);
    chk16("rst_if_rdata", bus.o_if_rdata, 16'h0000);

    // Fetch read and a load, both with literal timing/data.
    read_txn(1'b0, 16'h0010, 16'hABCD, "fetch");
    read_txn(1'b1, 16'h0201, 16'h5A5A, "load");

    // Store: write enable and data held, done in cycle 3, ls_rdata untouched.
    nxt(); bus.i_ls_req = 1'b1; bus.i_ls_we = 1'b1; bus.i_ls_addr = 16'h0200;
    bus.i_ls_wdata = 16'h1234; ev();
    chk1("st_gnt0", bus.o_ls_gnt, 1'b1);
    nxt(); bus.i_ls_req = 1'b0; ev();
    chk1("st_we1", bus.o_mem_we, 1'b1);
    chk16("st_wdata1", bus.o_mem_wdata, 16'h1234);
    nxt(); ev();
    chk1("st_we2", bus.o_mem_we, 1'b1);
    nxt(); ev();
    chk1("st_done3", bus.o_ls_done, 1'b1);
    chk16("st_rdata3", bus.o_ls_rdata, 16'h5A5A);
    nxt(); clear_in(); ev();

    // Contention with both requests held: grant pattern every W+2 cycles.
`ifdef MEM_PORT_ARB_RR_EN
    exp_ls = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_ls = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
    do_reset();
    for (int k = 0; k < 24; k++) begin
      nxt();
      bus.i_if_req = 1'b1; bus.i_if_addr = 16'h0100;
      bus.i_ls_req = 1'b1; bus.i_ls_we = 1'b0; bus.i_ls_addr = 16'h0300;
      ev();
      if (k % 4 == 0) begin
        chk1("cont_ls_gnt", bus.o_ls_gnt, exp_ls[k / 4]);
        chk1("cont_if_gnt", bus.o_if_gnt, !exp_ls[k / 4]);
      end
    end
    nxt(); clear_in(); ev();

    // Reset during the first access cycle of a fetch aborts it.
    do_reset();
    nxt(); bus.i_if_req = 1'b1; bus.i_if_addr = 16'h0040; ev();
    nxt(); bus.i_if_req = 1'b0; rst = 1'b1; ev();
    chk1("abort_en1", bus.o_mem_en, 1'b1);
    nxt(); rst = 1'b0; ev();
    chk1("abort_en2", bus.o_mem_en, 1'b0);
    chk1("abort_busy2", bus.o_busy, 1'b0);
    chk1("abort_rv2", bus.o_if_rvalid, 1'b0);
    nxt(); ev();
    chk1("abort_rv3", bus.o_if_rvalid, 1'b0);
    read_txn(1'b0, 16'h0044, 16'h7777, "refetch");

    // Request dropped and address changed right after grant.
    nxt(); bus.i_if_req = 1'b1; bus.i_if_addr = 16'h0010; ev();
    nxt(); bus.i_if_req = 1'b0; bus.i_if_addr = 16'hFFFF; ev();
    chk16("drop_addr1", bus.o_mem_addr, 16'h0010);
    nxt(); ev();
    chk16("drop_addr2", bus.o_mem_addr, 16'h0010);
    nxt(); ev();
    chk1("drop_rv3", bus.o_if_rvalid, 1'b1);
    nxt(); clear_in(); ev();

    // Random traffic: requests held until granted, occasional reset.
    pend_if = 1'b0;
    pend_ls = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      nxt();
      rst = ($urandom_range(0, 199) == 0);
      if (!pend_if) begin
        bus.i_if_req  = ($urandom_range(0, 2) != 0);
        bus.i_if_addr = 16'($urandom);
      end
      if (!pend_ls) begin
        bus.i_ls_req   = ($urandom_range(0, 2) != 0);
        bus.i_ls_we    = $urandom_range(0, 1) == 1;
        bus.i_ls_addr  = 16'($urandom);
        bus.i_ls_wdata = 16'($urandom);
      end
      bus.i_mem_rdata = 16'($urandom);
      ev();
      pend_if = bus.i_if_req && !m_w_if;
      pend_ls = bus.i_ls_req && !m_w_ls;
    end
    nxt(); rst = 1'b0; clear_in(); ev();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
